booth_mul_arbiter: RTL and testbench
====================================

// Module: booth_mul_arbiter
// PURPOSE
//  Shares one sequential Booth multiplier (start/valid handshake, signed WIDTH x WIDTH -> 2*WIDTH)
//  between NREQ requesters. Round-robin arbitration, operand capture, one start pulse per job,
//  completion detect, result routing back to the owner, and a watchdog that reports a stuck multiplier.
//  Sits between requesting datapath blocks and the single multiplier instance.
// PARAMETERS
//  NREQ    4   number of requesters (>=2)
//  WIDTH   4   signed operand width; product width is 2*WIDTH
//  TIMEOUT 32  max cycles spent in WAIT before the job is aborted with err (>=4)
// PORTS
//  clk       in   1              clock, all logic on rising edge
//  rst       in   1              asynchronous, active-low reset
//  req       in   NREQ           req[i]=1: requester i has a job; held with operands until gnt[i]
//  op_x      in   NREQ*WIDTH     signed X operands, requester i at [i*WIDTH +: WIDTH]
//  op_y      in   NREQ*WIDTH     signed Y operands, same packing
//  gnt       out  NREQ           one-hot, 1-cycle pulse: job from requester i accepted
//  done      out  NREQ           one-hot, 1-cycle pulse: job of requester i finished
//  result    out  2*WIDTH        signed product; valid while any done bit is high, holds afterwards
//  err       out  1              high with done when job ended by watchdog (result=0)
//  busy      out  1              high in every state except IDLE
//  mul_start out  1              1-cycle start pulse to the multiplier
//  mul_x     out  WIDTH          captured X, stable from grant until completion
//  mul_y     out  WIDTH          captured Y, stable from grant until completion
//  mul_valid in   1              multiplier done flag (level; may stay high until next start)
//  mul_z     in   2*WIDTH        multiplier product
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rr pointer=0, gnt=0, done=0, err=0, result=0, mul_start=0,
//   mul_x=mul_y=0, wdog=0, armed=0, busy=0. Reset mid-job aborts silently: no done, no err.
//  FSM: IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: on an edge where |req: pick first set req at or after pointer (wrapping mod NREQ) = k;
//   register gnt[k]=1, mul_start=1, mul_x/mul_y=op_x/op_y slice k, owner=k, pointer=(k+1)%NREQ,
//   wdog=0, armed=0; go WAIT. No req: stay, outputs low.
//  WAIT: gnt and mul_start are high exactly the first WAIT cycle, low afterwards. wdog increments each cycle.
//   armed<=1 when mul_valid sampled 0 (ignores stale valid from previous job).
//   armed && mul_valid: result<=mul_z, done[owner]<=1, err<=0; go DONE.
//   else if wdog==TIMEOUT-1: result<=0, done[owner]<=1, err<=1; go DONE.
//   Completion wins if both conditions hold on the same edge.
//  DONE: done/err high this one cycle; next edge clears done/err, go IDLE. req ignored in WAIT/DONE.
//  Latency: req high in IDLE at edge t -> gnt at t+1; done = 2 cycles after multiplier completion
//   edge (sample + DONE). Min spacing between grants: job time + 2 cycles.
//  Fairness: requester holding req waits at most NREQ-1 other jobs. Dropping req before gnt withdraws it.
//  Re-request: req still high in IDLE after done is a new job (operands re-sampled).
//  Arithmetic: mul_z passed unmodified; no sign extension or rounding inside this block.
//  mul_valid edges outside WAIT are ignored. result holds last value until next completion.
// TESTING
//  1 Reset: rst=0 with req=4'b1111 -> all outputs 0; release -> first gnt=4'b0001.
//  2 Single job: req[0], X=5,Y=7 -> gnt[0] 1 cycle, one mul_start, done[0] with result=35, err=0.
//  3 Signed: req[2], X=-4,Y=6 -> result=-24 on done[2]; X=-8,Y=-8 -> 64; X=7,Y=-8 -> -56.
//  4 Round-robin: req=4'b1011 held permanently -> grant order 0,1,3,0,1,3; one job in flight only.
//  5 Stale valid: model leaves mul_valid high until next start -> no early done; done after real finish.
//  6 Watchdog: model never asserts valid -> done[owner]+err at TIMEOUT cycles after grant, result=0;
//    then rst=0 mid-WAIT of next job -> no done, state IDLE, pointer=0.

Source files
------------

// File: rtl/booth_mul_arbiter_if.sv
// Bundle between the requester/multiplier side and the Booth multiplier arbiter.
// The arbiter uses the slave modport; whoever drives requests and models the multiplier uses master.
interface booth_mul_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_x;
  logic [NREQ*WIDTH-1:0] op_y;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [2*WIDTH-1:0]    result;
  logic                  err;
  logic                  busy;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_x;
  logic [WIDTH-1:0]      mul_y;
  logic                  mul_valid;
  logic [2*WIDTH-1:0]    mul_z;

  modport slave (
    input  req, op_x, op_y, mul_valid, mul_z,
    output gnt, done, result, err, busy, mul_start, mul_x, mul_y
  );

  modport master (
    output req, op_x, op_y, mul_valid, mul_z,
    input  gnt, done, result, err, busy, mul_start, mul_x, mul_y
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among NREQ requesters,
// with operand capture, result routing to the job owner and a stuck-multiplier watchdog.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  booth_mul_arbiter_if.slave   bus_if
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e               state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        owner_q;
  logic [NREQ-1:0]      gnt_q;
  logic [NREQ-1:0]      done_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 err_q;
  logic                 start_q;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     y_q;
  logic [WW-1:0]        wdog_q;
  logic                 armed_q;

  logic                 grantValid_d;
  logic [PW-1:0]        grantIdx_d;
  logic [PW-1:0]        ptr_d;
  int unsigned          scanIdx;

  // Scan from farthest to nearest so the first requester at/after the pointer wins.
  always_comb begin
    grantValid_d = 1'b0;
    grantIdx_d   = '0;
    scanIdx      = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      scanIdx = (int'(ptr_q) + j) % NREQ;
      if (bus_if.req[scanIdx]) begin
        grantValid_d = 1'b1;
        grantIdx_d   = PW'(scanIdx);
      end
    end
    ptr_d = PW'((int'(grantIdx_d) + 1) % NREQ);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      wdog_q   <= '0;
      armed_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q   <= '0;
          start_q <= 1'b0;
          done_q  <= '0;
          err_q   <= 1'b0;
          if (grantValid_d) begin
            gnt_q   <= NREQ'(1) << grantIdx_d;
            start_q <= 1'b1;
            x_q     <= bus_if.op_x[grantIdx_d*WIDTH +: WIDTH];
            y_q     <= bus_if.op_y[grantIdx_d*WIDTH +: WIDTH];
            owner_q <= grantIdx_d;
            ptr_q   <= ptr_d;
            wdog_q  <= '0;
            armed_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          gnt_q   <= '0;
          start_q <= 1'b0;
          wdog_q  <= wdog_q + 1'b1;
          // A valid level left over from the previous job only counts after a low sample.
          armed_q <= armed_q | ~bus_if.mul_valid;
          if (armed_q && bus_if.mul_valid) begin
            result_q <= bus_if.mul_z;
            done_q   <= NREQ'(1) << owner_q;
            err_q    <= 1'b0;
            state_q  <= DONE;
          end else if (wdog_q == WW'(TIMEOUT - 1)) begin
            result_q <= '0;
            done_q   <= NREQ'(1) << owner_q;
            err_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.gnt       = gnt_q;
  assign bus_if.done      = done_q;
  assign bus_if.result    = result_q;
  assign bus_if.err       = err_q;
  assign bus_if.busy      = (state_q != IDLE);
  assign bus_if.mul_start = start_q;
  assign bus_if.mul_x     = x_q;
  assign bus_if.mul_y     = y_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench: behavioural multiplier stand-in plus a round-robin/product reference model.
module tb_booth_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  booth_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int rrPtr = 0;
  int mulLat = 3;
  bit mulHang = 1'b0;
  int startCount = 0;
  int mulCnt = 0;
  logic [2*WIDTH-1:0] mulProd;

  // Multiplier stand-in: valid rises mulLat cycles after start and stays high until the next start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mul_valid <= 1'b0;
      bus.mul_z     <= '0;
      mulCnt        <= 0;
    end else if (bus.mul_start) begin
      startCount    <= startCount + 1;
      bus.mul_valid <= 1'b0;
      bus.mul_z     <= (2*WIDTH)'($urandom);
      mulProd       <= (2*WIDTH)'(int'($signed(bus.mul_x)) * int'($signed(bus.mul_y)));
      mulCnt        <= mulLat;
    end else if (mulCnt > 0) begin
      mulCnt <= mulCnt - 1;
      if (mulCnt == 1 && !mulHang) begin
        bus.mul_valid <= 1'b1;
        bus.mul_z     <= mulProd;
      end
    end
  end

  function automatic int exp_grant(input logic [NREQ-1:0] mask);
    for (int j = 0; j < NREQ; j++) begin
      if (mask[(rrPtr + j) % NREQ]) return (rrPtr + j) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [2*WIDTH-1:0] exp_prod(input int x, input int y);
    return (2*WIDTH)'(x * y);
  endfunction

  task automatic set_ops(input int i, input int x, input int y);
    bus.op_x[i*WIDTH +: WIDTH] = WIDTH'(x);
    bus.op_y[i*WIDTH +: WIDTH] = WIDTH'(y);
  endtask

  // Waits for one grant then its done, both bounded; a missing event shows up as zero vectors.
  task automatic do_job(input bit dropOnGnt, output int gIdx, output int lat,
                        output logic [NREQ-1:0] gVec, output logic [NREQ-1:0] dVec,
                        output logic [2*WIDTH-1:0] res, output logic e,
                        output int starts, output bit extraGnt);
    int n;
    int s0;
    gIdx = -1; lat = 0; gVec = '0; dVec = '0; res = '0; e = 1'b0; starts = 0; extraGnt = 1'b0;
    n = 0;
    while (bus.gnt == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.gnt == '0) return;
    gVec = bus.gnt;
    for (int i = 0; i < NREQ; i++) if (gVec[i]) gIdx = i;
    s0 = startCount;
    if (dropOnGnt) begin
      bus.req[gIdx] = 1'b0;
      set_ops(gIdx, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    while (bus.done == '0 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.gnt != '0) extraGnt = 1'b1;
    end
    dVec   = bus.done;
    res    = bus.result;
    e      = bus.err;
    starts = startCount - s0;
  endtask

  task automatic test_reset();
    int g, lat, st;
    logic [NREQ-1:0] gv, dv;
    logic [2*WIDTH-1:0] r;
    logic e;
    bit xg;
    rst_n = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, i + 2);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.gnt, bus.done, bus.err, bus.busy, bus.mul_start} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got gnt=%b done=%b err=%b busy=%b start=%b required all 0",
               bus.gnt, bus.done, bus.err, bus.busy, bus.mul_start);
    end
    checks++;
    if (bus.result !== '0) begin
      errors++;
      $display("[TB] FAIL reset_result got %h required 0", bus.result);
    end
    checks++;
    if ({bus.mul_x, bus.mul_y} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_operands got x=%h y=%h required 0", bus.mul_x, bus.mul_y);
    end
    rst_n = 1'b1;
    rrPtr = 0;
    mulLat = 2;
    @(negedge clk);
    do_job(1'b1, g, lat, gv, dv, r, e, st, xg);
    bus.req = '0;
    checks++;
    if (gv !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_first_gnt got %b required 0001", gv);
    end
    checks++;
    if (dv !== 4'b0001 || r !== exp_prod(1, 2)) begin
      errors++;
      $display("[TB] FAIL reset_first_job got done=%b result=%h required done=0001 result=%h",
               dv, r, exp_prod(1, 2));
    end
    rrPtr = 1;
  endtask

  task automatic test_single();
    int g, lat, st, eg;
    logic [NREQ-1:0] gv, dv;
    logic [2*WIDTH-1:0] r;
    logic e;
    bit xg;
    set_ops(0, 5, 7);
    bus.req = 4'b0001;
    eg = exp_grant(4'b0001);
    mulLat = 3;
    do_job(1'b1, g, lat, gv, dv, r, e, st, xg);
    rrPtr = (eg + 1) % NREQ;
    checks++;
    if (g !== eg || xg) begin
      errors++;
      $display("[TB] FAIL single_gnt got idx=%0d extra=%0d required idx=%0d extra=0", g, xg, eg);
    end
    checks++;
    if (dv !== 4'b0001 || r !== exp_prod(5, 7) || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done got done=%b result=%0d err=%b required 0001/35/0", dv, $signed(r), e);
    end
    checks++;
    if (st !== 1 || lat !== mulLat + 2) begin
      errors++;
      $display("[TB] FAIL single_timing got starts=%0d latency=%0d required 1/%0d", st, lat, mulLat + 2);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== '0 || bus.result !== exp_prod(5, 7) || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_hold got done=%b result=%h busy=%b required 0/%h/0",
               bus.done, bus.result, bus.busy, exp_prod(5, 7));
    end
  endtask

  task automatic test_signed();
    int xs[3] = '{-4, -8, 7};
    int ys[3] = '{6, -8, -8};
    int g, lat, st;
    logic [NREQ-1:0] gv, dv;
    logic [2*WIDTH-1:0] r;
    logic e;
    bit xg;
    for (int k = 0; k < 3; k++) begin
      set_ops(2, xs[k], ys[k]);
      bus.req = 4'b0100;
      mulLat = k + 1;
      do_job(1'b1, g, lat, gv, dv, r, e, st, xg);
      rrPtr = 3;
      checks++;
      if (dv !== 4'b0100 || r !== exp_prod(xs[k], ys[k]) || e !== 1'b0) begin
        errors++;
        $display("[TB] FAIL signed_%0d got done=%b result=%0d err=%b required 0100/%0d/0",
                 k, dv, $signed(r), e, xs[k] * ys[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    int g, lat, st, eg;
    logic [NREQ-1:0] gv, dv;
    logic [2*WIDTH-1:0] r;
    logic e;
    bit xg;
    for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, 3 - i);
    bus.req = 4'b1011;
    mulLat = 2;
    for (int k = 0; k < 6; k++) begin
      eg = exp_grant(4'b1011);
      do_job(1'b0, g, lat, gv, dv, r, e, st, xg);
      rrPtr = (eg + 1) % NREQ;
      checks++;
      if (g !== eg || xg || dv !== gv || r !== exp_prod(eg + 1, 3 - eg)) begin
        errors++;
        $display("[TB] FAIL rr_job_%0d got idx=%0d extra=%0d done=%b result=%h required idx=%0d done=one-hot result=%h",
                 k, g, xg, dv, r, eg, exp_prod(eg + 1, 3 - eg));
      end
    end
    bus.req = '0;
  endtask

  task automatic test_random();
    int g, lat, st, eg;
    int ox[NREQ];
    int oy[NREQ];
    logic [NREQ-1:0] mask, gv, dv;
    logic [2*WIDTH-1:0] r;
    logic e;
    bit xg;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        ox[i] = int'($urandom_range(0, 15)) - 8;
        oy[i] = int'($urandom_range(0, 15)) - 8;
        set_ops(i, ox[i], oy[i]);
      end
      mask = NREQ'($urandom_range(1, 15));
      mulLat = int'($urandom_range(1, 6));
      bus.req = mask;
      eg = exp_grant(mask);
      do_job(1'b1, g, lat, gv, dv, r, e, st, xg);
      bus.req = '0;
      rrPtr = (eg + 1) % NREQ;
      checks++;
      if (g !== eg || dv !== gv || r !== exp_prod(ox[eg], oy[eg]) || e !== 1'b0
          || lat !== mulLat + 2 || st !== 1) begin
        errors++;
        $display("[TB] FAIL random_%0d got idx=%0d done=%b result=%h err=%b lat=%0d starts=%0d required idx=%0d result=%h err=0 lat=%0d starts=1",
                 k, g, dv, r, e, lat, st, eg, exp_prod(ox[eg], oy[eg]), mulLat + 2);
      end
    end
  endtask

  task automatic test_stale_valid();
    int g, lat, st;
    logic [NREQ-1:0] gv, dv;
    logic [2*WIDTH-1:0] r;
    logic e;
    bit xg;
    set_ops(1, 3, -5);
    bus.req = 4'b0010;
    mulLat = 6;
    do_job(1'b1, g, lat, gv, dv, r, e, st, xg);
    rrPtr = 2;
    checks++;
    if (lat !== mulLat + 2 || dv !== 4'b0010 || r !== exp_prod(3, -5)) begin
      errors++;
      $display("[TB] FAIL stale_valid got lat=%0d done=%b result=%h required lat=%0d done=0010 result=%h",
               lat, dv, r, mulLat + 2, exp_prod(3, -5));
    end
  endtask

  task automatic test_watchdog();
    int g, lat, st, n;
    logic [NREQ-1:0] gv, dv;
    logic [2*WIDTH-1:0] r;
    logic e;
    bit xg;
    mulHang = 1'b1;
    set_ops(1, 2, 3);
    bus.req = 4'b0010;
    do_job(1'b1, g, lat, gv, dv, r, e, st, xg);
    rrPtr = 2;
    checks++;
    if (dv !== 4'b0010 || e !== 1'b1 || r !== '0 || lat !== TIMEOUT) begin
      errors++;
      $display("[TB] FAIL watchdog got done=%b err=%b result=%h lat=%0d required 0010/1/0/%0d",
               dv, e, r, lat, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.done !== '0) begin
      errors++;
      $display("[TB] FAIL watchdog_clear got done=%b err=%b required 0/0", bus.done, bus.err);
    end
    set_ops(3, 1, 1);
    bus.req = 4'b1000;
    n = 0;
    while (bus.gnt == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.req = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midjob_busy got %b required 1", bus.busy);
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.done !== '0 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== '0) begin
        errors++;
        $display("[TB] FAIL midjob_reset got done=%b err=%b busy=%b gnt=%b required all 0",
                 bus.done, bus.err, bus.busy, bus.gnt);
      end
    end
    mulHang = 1'b0;
    mulLat = 2;
    rrPtr = 0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 1, 1);
    bus.req = 4'b1111;
    rst_n = 1'b1;
    do_job(1'b1, g, lat, gv, dv, r, e, st, xg);
    bus.req = '0;
    checks++;
    if (gv !== 4'b0001 || dv !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL after_reset_ptr got gnt=%b done=%b required 0001/0001", gv, dv);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    bus.req  = '0;
    bus.op_x = '0;
    bus.op_y = '0;
    test_reset();
    test_single();
    test_signed();
    test_round_robin();
    test_random();
    test_stale_valid();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
